// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: state encoding, PC width and parameter defaults.
package pc_seq_pkg;

    localparam int unsigned PcWidth = 32;
    localparam logic [PcWidth-1:0] ResetPcDefault = 32'h0000_0000;
    localparam int unsigned PcStepDefault = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StFetch  = 2'b01,
        StIssue  = 2'b10,
        StHalted = 2'b11
    } state_e;

endpackage

// File: rtl/pc_reg.sv
// Program-counter register with synchronous active-high reset and load enable.
module pc_reg
    import pc_seq_pkg::*;
#(
    parameter logic [PcWidth-1:0] RESET_VAL = ResetPcDefault
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               load_en,
    input  logic [PcWidth-1:0] d,
    output logic [PcWidth-1:0] q
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            q <= RESET_VAL;
        end else if (load_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/issue sequencer: requests one instruction at PC, issues it, then advances or branches.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PcWidth-1:0] RESET_PC = ResetPcDefault,
    parameter int unsigned        PC_STEP  = PcStepDefault
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               HALT_REQ,
    input  logic               STALL,
    input  logic               BR_TAKEN,
    input  logic [PcWidth-1:0] BR_TARGET,
    output logic               IMEM_REQ,
    output logic [PcWidth-1:0] IMEM_ADDR,
    input  logic               IMEM_ACK,
    input  logic [31:0]        IMEM_DATA,
    output logic [31:0]        INSTR,
    output logic               INSTR_VALID,
    output logic [PcWidth-1:0] PC,
    output logic [1:0]         STATE
);

    state_e             state_q, state_d;
    logic [31:0]        instr_q, instr_d;
    logic [PcWidth-1:0] pc_q, pc_next;
    logic               pc_load;

    pc_reg #(
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .CLK     (CLK),
        .RST     (RST),
        .load_en (pc_load),
        .d       (pc_next),
        .q       (pc_q)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_load = 1'b0;
        pc_next = pc_q + PcWidth'(PC_STEP);
        unique case (state_q)
            StIdle, StHalted: begin
                if (START) state_d = StFetch;
            end
            StFetch: begin
                if (IMEM_ACK) begin
                    instr_d = IMEM_DATA;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // Branch/halt only matter on the cycle the instruction actually retires.
                if (!STALL) begin
                    pc_load = 1'b1;
                    if (BR_TAKEN) pc_next = BR_TARGET & ~PcWidth'(3);
                    state_d = HALT_REQ ? StHalted : StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign IMEM_REQ    = (state_q == StFetch);
    assign INSTR_VALID = (state_q == StIssue);
    assign IMEM_ADDR   = pc_q;
    assign PC          = pc_q;
    assign INSTR       = instr_q;
    assign STATE       = state_q;

endmodule
